sfp_conv_chk: RTL and testbench
===============================

// Module: sfp_conv_chk
// PURPOSE
//  Synthesizable round-trip checker at the std end of the std->slf->std float chain.
//  Queues each IEEE-754 single presented to std2slf and compares it, in order, with the std word returned by slf2std.
//  The comparison allows for the 26-bit slf format: sign 1, exponent 8, mantissa 17.
//  Counts passes and fails and captures the first mismatch, for on-chip self-test and simulation.
// PARAMETERS
//  DEPTH     16  reference FIFO entries (power of 2); max outstanding conversions
//  AW        4   FIFO pointer width, log2(DEPTH)
//  MANT_DROP 6   std mantissa LSBs lost in slf (23-17); ignored in compare
//  CNT_W     32  pass/fail counter width
// PORTS
//  i_clk      in  1      clock, all logic on posedge
//  i_rst      in  1      reset, asynchronous, active-low
//  i_clr      in  1      sync clear: FIFO, counters, sticky flags, capture, FSM
//  i_ref_req  in  1      push i_ref_dat (same cycle as std2slf i_req)
//  i_ref_dat  in  32     original std word
//  i_cmp_req  in  1      pop and compare i_cmp_dat (slf2std o_vld)
//  i_cmp_dat  in  32     returned std word
//  o_ref_full out 1      FIFO holds DEPTH entries
//  o_pass_cnt out CNT_W  matched compares, saturating
//  o_fail_cnt out CNT_W  mismatched compares, saturating
//  o_err      out 1      sticky: any mismatch
//  o_err_exp  out 32     expected word of first mismatch
//  o_err_got  out 32     received word of first mismatch
//  o_ovf      out 1      sticky: push dropped while full
//  o_unf      out 1      sticky: compare while empty
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM=ST_RUN.
//  - i_clr beats push/pop in the same cycle. Effect equals reset; applied on the next edge.
//  - Push: writes at wr_ptr when not full. Pointers are AW+1 bits; full/empty use MSB compare, wrap is natural.
//  - Push while full, no pop: word dropped, o_ovf<=1.
//  - Push + pop in the same cycle while full: both execute, count unchanged, no ovf.
//  - Pop while empty: no bypass of a same-cycle push. Compare discarded, o_unf<=1, counters unchanged. Any push still executes.
//  - Expected value E from reference R:
//      R[30:23]==0      -> E={R[31],31'h0}  (zero/denormal flush, sign kept)
//      R[30:23]==8'hFF  -> inf if R[22:0]==0, else NaN class
//      otherwise        -> E={R[31:MANT_DROP],MANT_DROP'h0} (truncation)
//  - Match rules:
//      normal / zero / inf: i_cmp_dat==E exactly
//      NaN: any i_cmp_dat with exp==8'hFF and mant!=0
//  - Latency: the compare result is visible on counters, o_err and capture 1 cycle after i_cmp_req.
//  - Counters saturate at all-ones; no wrap.
//  - Capture: o_err_exp/o_err_got load only when o_err goes 0->1. Later fails do not overwrite.
//  - FSM: ST_RUN (normal) and ST_HALT (macro builds only). See CONFIGURATION.
//  - Reset mid-stream: FIFO contents abandoned. Words still in flight in the converters then compare against an empty FIFO and raise o_unf.
//    The bench applies reset only with the pipeline drained.
// CONFIGURATION
//  SFP_CHK_STOP_EN defined:
//    first mismatch moves FSM ST_RUN->ST_HALT
//    in ST_HALT: pushes and pops ignored, counters frozen, no ovf/unf updates
//    exit only via i_clr or i_rst -> ST_RUN
//  SFP_CHK_STOP_EN undefined:
//    ST_HALT absent; checker keeps counting after a fail; o_err sticky only
// TESTING
//  1. push 32'h3F800000, next cycle cmp 32'h3F800000 -> o_pass_cnt=1, o_err=0
//  2. push 32'h3F80003F, cmp 32'h3F800000 -> pass
//     push 32'h3F800000, cmp 32'h3F800040 -> o_fail_cnt=1, o_err=1, o_err_exp=32'h3F800000, o_err_got=32'h3F800040
//  3. push 32'h80000005, cmp 32'h80000000 -> pass
//     push 32'h7FC00001, cmp 32'h7F800100 -> pass (NaN class)
//     push 32'h7F800000, cmp 32'h7F800000 -> pass
//  4. 16 pushes, no cmp -> o_ref_full=1
//     17th push -> o_ovf=1, count 16
//     push+cmp in the same cycle while full -> no ovf, count 16
//  5. cmp 32'h12345678 with FIFO empty -> o_unf=1, both counters 0
//     i_clr -> all flags and counters 0
//  6. SFP_CHK_STOP_EN: force a fail, then 4 matching pairs -> o_pass_cnt frozen, FSM=ST_HALT
//     i_clr, then 1 matching pair -> o_pass_cnt=1

Source files
------------

// File: rtl/sfp_conv_chk.sv
// Round-trip checker for the std->slf->std float chain: queues reference words, compares returned words in order.
// Latency: compare result lands on counters/flags/capture on the edge that consumes i_cmp_req (visible 1 cycle later).
// Backpressure: none; o_ref_full is advisory, pushes while full are dropped and flagged on o_ovf.
//
// Optional feature macro: SFP_CHK_STOP_EN (halt on first mismatch until i_clr or reset).
//
// Ports:
//   i_clk, i_rst (async, active-low), i_clr (sync clear of all state)
//   i_ref_req/i_ref_dat : push original std word
//   i_cmp_req/i_cmp_dat : pop reference and compare against returned std word
//   o_ref_full          : reference FIFO holds DEPTH entries
//   o_pass_cnt/o_fail_cnt : saturating compare counters
//   o_err, o_err_exp, o_err_got : sticky mismatch flag and first-mismatch capture
//   o_ovf, o_unf        : sticky push-while-full-dropped / compare-while-empty flags

module sfp_conv_chk #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int MANT_DROP = 6,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_ref_req,
    input  logic [31:0]      i_ref_dat,
    input  logic             i_cmp_req,
    input  logic [31:0]      i_cmp_dat,
    output logic             o_ref_full,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic             o_err,
    output logic [31:0]      o_err_exp,
    output logic [31:0]      o_err_got,
    output logic             o_ovf,
    output logic             o_unf
);

`ifdef SFP_CHK_STOP_EN
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;
`else
    typedef enum logic {
        ST_RUN  = 1'b0
    } state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t          state_q, state_d;

    logic [31:0]     mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             err_q, err_d;
    logic [31:0]      err_exp_q, err_exp_d;
    logic [31:0]      err_got_q, err_got_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic            run_en;
    logic            fifo_full;
    logic            fifo_empty;
    logic            do_push;
    logic            do_pop;
    logic            pass_hit;
    logic            fail_hit;

    logic [31:0]     ref_w;
    logic [7:0]      ref_exp;
    logic [22:0]     ref_man;
    logic            ref_is_nan;
    logic            got_is_nan;
    logic [31:0]     exp_w;
    logic            match;

    // Extra pointer MSB distinguishes full from empty when the index bits meet.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign run_en = (state_q == ST_RUN);

    // Pop never bypasses a same-cycle push; a push into a full FIFO is only
    // accepted when a pop frees the slot on the same edge.
    assign do_pop  = run_en && i_cmp_req && !fifo_empty;
    assign do_push = run_en && i_ref_req && (!fifo_full || do_pop);

    // Expected word: slf keeps sign, exponent and the top 17 mantissa bits,
    // flushes denormals to signed zero, and preserves inf; any NaN payload is
    // acceptable on return, so NaN references only constrain the class.
    always_comb begin
        ref_w      = mem_q[rd_ptr_q[AW-1:0]];
        ref_exp    = ref_w[30:23];
        ref_man    = ref_w[22:0];
        ref_is_nan = (&ref_exp) && (|ref_man);
        got_is_nan = (&i_cmp_dat[30:23]) && (|i_cmp_dat[22:0]);
        exp_w      = ref_w;
        if (ref_exp == 8'h00) begin
            exp_w = {ref_w[31], 31'h0};
        end else if (&ref_exp) begin
            exp_w = ref_w;
        end else begin
            exp_w = {ref_w[31:MANT_DROP], {MANT_DROP{1'b0}}};
        end
        match = ref_is_nan ? got_is_nan : (i_cmp_dat == exp_w);
    end

    assign pass_hit = do_pop && match;
    assign fail_hit = do_pop && !match;

    // Next-state for pointers, counters, sticky flags and capture.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_d      = err_q;
        err_exp_d  = err_exp_q;
        err_got_d  = err_got_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (pass_hit && (pass_cnt_q != CNT_MAX)) begin
            pass_cnt_d = pass_cnt_q + 1'b1;
        end
        if (fail_hit && (fail_cnt_q != CNT_MAX)) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
        end

        // Capture only the first mismatch; later fails leave it intact.
        if (fail_hit) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_exp_d = exp_w;
                err_got_d = i_cmp_dat;
            end
        end

        if (run_en && i_ref_req && fifo_full && !do_pop) begin
            ovf_d = 1'b1;
        end
        if (run_en && i_cmp_req && fifo_empty) begin
            unf_d = 1'b1;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
`ifdef SFP_CHK_STOP_EN
        case (state_q)
            ST_RUN:  if (fail_hit) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_RUN;
        end else if (i_clr) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_q      <= 1'b0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (i_clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_q      <= 1'b0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_q      <= err_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage needs no reset: contents are only read between valid pointers.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_clr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_ref_dat;
        end
    end

    assign o_ref_full = fifo_full;
    assign o_pass_cnt = pass_cnt_q;
    assign o_fail_cnt = fail_cnt_q;
    assign o_err      = err_q;
    assign o_err_exp  = err_exp_q;
    assign o_err_got  = err_got_q;
    assign o_ovf      = ovf_q;
    assign o_unf      = unf_q;

endmodule

// File: tb/tb_sfp_conv_chk.sv
module tb_sfp_conv_chk;

    logic        i_clk;
    logic        i_rst;
    logic        i_clr;
    logic        i_ref_req;
    logic [31:0] i_ref_dat;
    logic        i_cmp_req;
    logic [31:0] i_cmp_dat;
    logic        o_ref_full;
    logic [31:0] o_pass_cnt;
    logic [31:0] o_fail_cnt;
    logic        o_err;
    logic [31:0] o_err_exp;
    logic [31:0] o_err_got;
    logic        o_ovf;
    logic        o_unf;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    sfp_conv_chk #(
        .DEPTH(16), .AW(4), .MANT_DROP(6), .CNT_W(32)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_clr),
        .i_ref_req  (i_ref_req),
        .i_ref_dat  (i_ref_dat),
        .i_cmp_req  (i_cmp_req),
        .i_cmp_dat  (i_cmp_dat),
        .o_ref_full (o_ref_full),
        .o_pass_cnt (o_pass_cnt),
        .o_fail_cnt (o_fail_cnt),
        .o_err      (o_err),
        .o_err_exp  (o_err_exp),
        .o_err_got  (o_err_got),
        .o_ovf      (o_ovf),
        .o_unf      (o_unf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_clr     = 1'b0;
        i_ref_req = 1'b0;
        i_cmp_req = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        i_ref_req = 1'b1;
        i_ref_dat = d;
        tick();
        idle();
    endtask

    task automatic cmp(input logic [31:0] d);
        i_cmp_req = 1'b1;
        i_cmp_dat = d;
        tick();
        idle();
    endtask

    task automatic pair(input logic [31:0] r, input logic [31:0] g);
        push(r);
        cmp(g);
    endtask

    task automatic clear();
        i_clr = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        logic [31:0] d;
        i_rst     = 1'b0;
        i_ref_dat = '0;
        i_cmp_dat = '0;
        idle();
        repeat (3) tick();

        // Reset state
        check("rst_pass",  o_pass_cnt, 32'd0);
        check("rst_fail",  o_fail_cnt, 32'd0);
        check("rst_err",   {31'd0, o_err}, 32'd0);
        check("rst_full",  {31'd0, o_ref_full}, 32'd0);
        check("rst_ovf",   {31'd0, o_ovf}, 32'd0);
        check("rst_unf",   {31'd0, o_unf}, 32'd0);
        check("rst_exp",   o_err_exp, 32'd0);
        i_rst = 1'b1;
        tick();

        // 1: exact match
        pair(32'h3F800000, 32'h3F800000);
        check("t1_pass", o_pass_cnt, 32'd1);
        check("t1_err",  {31'd0, o_err}, 32'd0);

        // 2: truncated LSBs ignored, then a real mismatch
        pair(32'h3F80003F, 32'h3F800000);
        check("t2_trunc_pass", o_pass_cnt, 32'd2);
        pair(32'h3F800000, 32'h3F800040);
        check("t2_fail_cnt", o_fail_cnt, 32'd1);
        check("t2_err",      {31'd0, o_err}, 32'd1);
        check("t2_err_exp",  o_err_exp, 32'h3F800000);
        check("t2_err_got",  o_err_got, 32'h3F800040);
`ifndef SFP_CHK_STOP_EN
        // A second fail keeps counting but does not overwrite the capture.
        pair(32'h40000000, 32'h40400000);
        check("t2_fail_cnt2", o_fail_cnt, 32'd2);
        check("t2_exp_keep",  o_err_exp, 32'h3F800000);
        check("t2_got_keep",  o_err_got, 32'h3F800040);
`endif
        clear();
        check("clr_fail", o_fail_cnt, 32'd0);
        check("clr_err",  {31'd0, o_err}, 32'd0);
        check("clr_got",  o_err_got, 32'd0);

        // 3: denormal flush, NaN class, infinity
        pair(32'h80000005, 32'h80000000);
        pair(32'h7FC00001, 32'h7F800100);
        pair(32'h7F800000, 32'h7F800000);
        check("t3_pass", o_pass_cnt, 32'd3);
        check("t3_fail", o_fail_cnt, 32'd0);

        // 4: fill, simultaneous push/pop while full, overflow drop
        for (int i = 0; i < 16; i++) begin
            d = 32'h40000000 | (i << 6);
            push(d);
        end
        check("t4_full", {31'd0, o_ref_full}, 32'd1);
        check("t4_no_ovf_fill", {31'd0, o_ovf}, 32'd0);
        i_ref_req = 1'b1; i_ref_dat = 32'h41000000;
        i_cmp_req = 1'b1; i_cmp_dat = 32'h40000000;
        tick();
        idle();
        check("t4_pp_full", {31'd0, o_ref_full}, 32'd1);
        check("t4_pp_no_ovf", {31'd0, o_ovf}, 32'd0);
        check("t4_pp_pass", o_pass_cnt, 32'd4);
        push(32'h42000000);
        check("t4_ovf",  {31'd0, o_ovf}, 32'd1);
        check("t4_full2", {31'd0, o_ref_full}, 32'd1);
        // Drain: entries 1..15 then the word pushed alongside the pop; the dropped word is gone.
        for (int i = 1; i < 16; i++) begin
            d = 32'h40000000 | (i << 6);
            cmp(d);
        end
        cmp(32'h41000000);
        check("t4_drain_pass", o_pass_cnt, 32'd20);
        check("t4_drain_fail", o_fail_cnt, 32'd0);
        check("t4_empty", {31'd0, o_ref_full}, 32'd0);
        check("t4_no_unf", {31'd0, o_unf}, 32'd0);

        // 5: underflow, clear priority over a same-cycle push
        clear();
        cmp(32'h12345678);
        check("t5_unf",  {31'd0, o_unf}, 32'd1);
        check("t5_pass", o_pass_cnt, 32'd0);
        check("t5_fail", o_fail_cnt, 32'd0);
        clear();
        check("t5_clr_unf", {31'd0, o_unf}, 32'd0);
        check("t5_clr_ovf", {31'd0, o_ovf}, 32'd0);
        i_clr = 1'b1; i_ref_req = 1'b1; i_ref_dat = 32'h3F800000;
        tick();
        idle();
        cmp(32'h3F800000);
        check("t5_clr_beats_push", {31'd0, o_unf}, 32'd1);
        clear();

        // Sign of a flushed denormal is kept.
        pair(32'h00000001, 32'h80000000);
        check("t5_sign_fail", o_fail_cnt, 32'd1);
        check("t5_sign_exp",  o_err_exp, 32'h00000000);
        clear();

        // 6: behaviour after a fail
        pair(32'h3F800000, 32'h3F800040);
        for (int i = 0; i < 4; i++) pair(32'h40800000, 32'h40800000);
`ifdef SFP_CHK_STOP_EN
        check("t6_halt_pass", o_pass_cnt, 32'd0);
        check("t6_halt_fail", o_fail_cnt, 32'd1);
        clear();
        pair(32'h40800000, 32'h40800000);
        check("t6_resume_pass", o_pass_cnt, 32'd1);
`else
        check("t6_run_pass", o_pass_cnt, 32'd4);
        check("t6_run_fail", o_fail_cnt, 32'd1);
        check("t6_run_err",  {31'd0, o_err}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
